tick_period_meter: RTL
======================

TICK_PERIOD_METER -- requirements
Module: tick_period_meter

Interface
REQ-001 The block SHALL have parameter CNT_W, default 32, giving the width of the period counter and of the period outputs.
REQ-002 The block SHALL have parameter TIMEOUT, default 1000, giving the number of cycles without a tick edge before timeout is declared; legal range 2 to 2^CNT_W-1.
REQ-003 The block SHALL have port clk_in, input, 1 bit: the clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port tick_in, input, 1 bit: the tick stream under measurement, synchronous to clk_in.
REQ-006 The block SHALL have port clear, input, 1 bit: synchronous restart of measurement and statistics.
REQ-007 The block SHALL have port period, output, CNT_W bits: the last measured edge-to-edge interval in clk_in cycles.
REQ-008 The block SHALL have port period_valid, output, 1 bit: a one-cycle pulse when period updates.
REQ-009 The block SHALL have port min_period, output, CNT_W bits: the smallest valid period since reset or clear.
REQ-010 The block SHALL have port max_period, output, CNT_W bits: the largest valid period since reset or clear.
REQ-011 The block SHALL have port timeout_flag, output, 1 bit: level, high while no edge has arrived within TIMEOUT cycles.
REQ-012 The block SHALL have port edge_count, output, 16 bits: the number of rising edges seen since reset or clear.

Function
REQ-013 A rising edge SHALL be detected in cycle E when tick_in=1 and the registered previous tick_in=0; a constantly high tick_in SHALL count as one edge.
REQ-014 The FSM SHALL have exactly three states: IDLE (no edge yet), RUN (timing an interval) and STALL (timed out).
REQ-015 In IDLE, an edge SHALL move the FSM to RUN with the interval counter set to 1; no period is reported.
REQ-016 In RUN, the counter SHALL increment by 1 each cycle with no edge.
REQ-017 On an edge in RUN, period SHALL take the counter value, period_valid SHALL pulse for one cycle, and the counter SHALL reload to 1, all visible in cycle E+1.
REQ-018 Period semantics SHALL be: edges N cycles apart report period=N.
REQ-019 min_period and max_period SHALL be updated in the same cycle E+1 using that new period.
REQ-020 The update SHALL compare the new period against the old min and max, so the first valid period sets both min and max.
REQ-021 In RUN, when the counter reaches TIMEOUT with no edge, the FSM SHALL enter STALL and timeout_flag SHALL go to 1 in the next cycle; no period is reported.
REQ-022 In STALL, the counter SHALL hold, and an edge SHALL return the FSM to RUN with the counter at 1 and timeout_flag at 0; that interval is invalid and no period_valid is produced.
REQ-023 An edge in the same cycle that the counter reaches TIMEOUT SHALL win: a valid period equal to TIMEOUT is reported and the FSM stays in RUN.
REQ-024 edge_count SHALL increment on every detected edge in any state and SHALL wrap from 65535 to 0.
REQ-025 The interval counter SHALL never wrap; it saturates at TIMEOUT.
REQ-026 Priority SHALL be reset over clear over edge/count activity.
REQ-027 clear SHALL restore the reset values of REQ-028 in the next cycle; an edge coincident with clear SHALL be ignored, but the previous-tick register still updates.

Reset
REQ-028 On reset, the block SHALL set the FSM to IDLE; counter, period, max_period and edge_count to 0; min_period to all-ones; period_valid and timeout_flag to 0; and the previous-tick register to 0.
REQ-029 Reset asserted mid-interval SHALL discard the partial interval; a tick_in held high across reset release SHALL count as an edge in the first cycle after release.

Structure
REQ-030 The FSM state encoding and the reset value of min_period (all-ones of CNT_W) SHALL live in the shared package, tick_pkg.
REQ-031 Edge detection SHALL be one natural sub-module, tick_edge_detect, with inputs clk_in, reset and tick_in and output rise; all other logic stays in tick_period_meter.

Verification
REQ-032 Test: 1-cycle pulses on tick_in every 4 cycles, 5 edges -> 4 period_valid pulses with period=4, min_period=4, max_period=4, edge_count=5.
REQ-033 Test: with TIMEOUT=10, edges at cycles 0, 6 and 15 -> periods 6 then 9, min_period=6, max_period=9, timeout_flag stays 0.
REQ-034 Test: with TIMEOUT=10, one edge then 12 idle cycles -> timeout_flag=1 one cycle after the counter hits 10; the next edge clears the flag with no period_valid; the edge after that, 3 cycles later, reports period=3.
REQ-035 Test: with TIMEOUT=10, edges exactly 10 cycles apart -> period=10 reported, timeout_flag stays 0.
REQ-036 Test: tick_in held high for 20 cycles -> edge_count=1 and no period_valid.
REQ-037 Test: clear asserted mid-interval coincident with an edge after max_period=7 -> next cycle max_period=0, min_period all-ones, edge_count=0, FSM IDLE; 65536 edges from reset -> edge_count wraps to 0.

Source files
------------

// File: rtl/tick_pkg.sv
// Shared definitions for the tick period meter.
// - tick_state_e     : measurement FSM encoding (IDLE / RUN / STALL)
// - MAX_CNT_W        : widest period counter the package constants cover
// - MIN_PERIOD_RESET : all-ones start value for min_period; the meter slices
//                      off its own CNT_W bits so any width up to MAX_CNT_W works
package tick_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } tick_state_e;

  localparam int MAX_CNT_W = 64;

  localparam logic [MAX_CNT_W-1:0] MIN_PERIOD_RESET = {MAX_CNT_W{1'b1}};

endpackage

// File: rtl/tick_edge_detect.sv
// Rising-edge detector for the tick stream.
// Ports:
//   clk_in  - clock, rising edge
//   reset   - synchronous active-high reset; clears the previous-tick register
//   tick_in - tick stream, synchronous to clk_in
//   rise    - high in the cycle where tick_in=1 and the previous sample was 0
// rise is combinational so the meter can act on the edge in the same cycle.
// A tick held high through reset release is reported as an edge in the first
// cycle after release because the previous sample was forced to 0.
module tick_edge_detect
  import tick_pkg::*;
(
  input  logic clk_in,
  input  logic reset,
  input  logic tick_in,
  output logic rise
);

  logic prev_q;
  logic prev_d;

  // Next value of the previous-tick register is simply the current tick.
  always_comb begin
    prev_d = tick_in;
  end

  // Previous-tick register; keeps tracking tick_in even during a clear.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise = tick_in & ~prev_q;

endmodule

// File: rtl/tick_period_meter.sv
// Measures the interval between rising edges of tick_in in clk_in cycles and
// keeps min/max statistics, an edge counter and a timeout indication.
// Parameters:
//   CNT_W   - width of the interval counter and period outputs (<= 64)
//   TIMEOUT - cycles without an edge before timeout (2 .. 2^CNT_W-1)
// Ports:
//   clk_in       - clock, rising edge
//   reset        - synchronous active-high reset
//   tick_in      - tick stream under measurement
//   clear        - synchronous restart of measurement and statistics
//   period       - last measured edge-to-edge interval
//   period_valid - one-cycle pulse when period updates
//   min_period   - smallest period since reset/clear (all-ones when none)
//   max_period   - largest period since reset/clear (0 when none)
//   timeout_flag - high while no edge arrived within TIMEOUT cycles
//   edge_count   - rising edges seen since reset/clear, wraps at 16 bits
module tick_period_meter
  import tick_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1000
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             tick_in,
  input  logic             clear,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic [CNT_W-1:0] min_period,
  output logic [CNT_W-1:0] max_period,
  output logic             timeout_flag,
  output logic [15:0]      edge_count
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_RST   = MIN_PERIOD_RESET[CNT_W-1:0];

  logic             rise;

  tick_state_e      state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q,  valid_d;
  logic [CNT_W-1:0] min_q,    min_d;
  logic [CNT_W-1:0] max_q,    max_d;
  logic             flag_q,   flag_d;
  logic [15:0]      ecnt_q,   ecnt_d;

  tick_edge_detect u_edge (
    .clk_in  (clk_in),
    .reset   (reset),
    .tick_in (tick_in),
    .rise    (rise)
  );

  // Next-state logic: clear restarts everything, otherwise the FSM times
  // the interval and publishes a period on each edge seen while in RUN.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    valid_d  = 1'b0;
    min_d    = min_q;
    max_d    = max_q;
    flag_d   = flag_q;
    ecnt_d   = ecnt_q;

    if (clear) begin
      // A coincident edge is deliberately dropped here.
      state_d  = ST_IDLE;
      cnt_d    = CNT_ZERO;
      period_d = CNT_ZERO;
      min_d    = MIN_RST;
      max_d    = CNT_ZERO;
      flag_d   = 1'b0;
      ecnt_d   = 16'd0;
    end else begin
      if (rise) begin
        ecnt_d = ecnt_q + 16'd1;
      end else begin
        ecnt_d = ecnt_q;
      end

      case (state_q)
        ST_IDLE: begin
          if (rise) begin
            state_d = ST_RUN;
            cnt_d   = CNT_ONE;
          end else begin
            state_d = ST_IDLE;
          end
        end

        ST_RUN: begin
          // The edge is checked first so an edge landing exactly on
          // TIMEOUT still yields a valid period.
          if (rise) begin
            period_d = cnt_q;
            valid_d  = 1'b1;
            cnt_d    = CNT_ONE;
            min_d    = (cnt_q < min_q) ? cnt_q : min_q;
            max_d    = (cnt_q > max_q) ? cnt_q : max_q;
          end else if (cnt_q >= TIMEOUT_C) begin
            // Counter saturates here; it is never incremented past TIMEOUT.
            state_d = ST_STALL;
            flag_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        ST_STALL: begin
          // The interval that ends here was too long: restart silently.
          if (rise) begin
            state_d = ST_RUN;
            cnt_d   = CNT_ONE;
            flag_d  = 1'b0;
          end else begin
            state_d = ST_STALL;
          end
        end

        default: begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
          flag_d  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= CNT_ZERO;
      period_q <= CNT_ZERO;
      valid_q  <= 1'b0;
      min_q    <= MIN_RST;
      max_q    <= CNT_ZERO;
      flag_q   <= 1'b0;
      ecnt_q   <= 16'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      min_q    <= min_d;
      max_q    <= max_d;
      flag_q   <= flag_d;
      ecnt_q   <= ecnt_d;
    end
  end

  assign period       = period_q;
  assign period_valid = valid_q;
  assign min_period   = min_q;
  assign max_period   = max_q;
  assign timeout_flag = flag_q;
  assign edge_count   = ecnt_q;

endmodule
